song_reader: RTL and testbench
==============================

# song_reader

Song sequencer for the music-player datapath. It sits between the MCU (song select, play/pause) and the note player. It walks a 4-song × 32-note ROM, emits each note/duration pair with a one-cycle `new_note` strobe, and advances on `note_done`. It supports fast-forward (halved durations), rewind (reverse order) and an `activate`/`activate_done` handshake to a downstream block before each note is issued.

## Interface
Parameters:
- `NOTES_PER_SONG`, 32: notes per song; index width 5.
- `ROM_DEPTH`, 128: 4 songs × 32 entries, 12-bit words {note[11:6], duration[5:0]}.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock domain.
- `play`  in  1  level; 1 = run, 0 = pause.
- `song`  in  2  song select; ROM address = {song, note_idx}.
- `note_done`  in  1  note player finished current note.
- `ff_switch0`  in  1  fast-forward: output duration halved.
- `r_switch1`  in  1  rewind: note index decrements.
- `activate_done`  in  1  downstream acknowledge of `activate`.
- `note`  out  6  current note code (0 = rest).
- `duration`  out  6  current duration (after ff scaling).
- `new_note`  out  1  one-cycle strobe: `note`/`duration` valid and new.
- `song_done`  out  1  one-cycle strobe: last note of song completed.
- `activate`  out  1  request to downstream; held until `activate_done`.

## Operation
- States: IDLE, FETCH, LOAD, ACT, NEW, WAIT, NEXT.
- IDLE: outputs hold. If `play`=1, go to FETCH.
- FETCH: present address {song, note_idx} to the ROM.
- LOAD: register ROM data into `note`/`duration`. Duration = ff ? max(1, dur>>1) : dur. A stored duration of 0 stays 0.
- ACT: `activate`=1. Exit to NEW in the cycle `activate_done`=1 is sampled.
- NEW: `new_note`=1 for exactly one cycle, then go to WAIT.
- WAIT: hold outputs. Leave to NEXT only when `note_done`=1 and `play`=1. `note_done` is ignored while paused.
- NEXT, forward (`r_switch1`=0): note_idx+1. If note_idx was 31, pulse `song_done`, wrap to 0 and go to IDLE; otherwise go to FETCH.
- NEXT, rewind (`r_switch1`=1): note_idx−1. If note_idx was 0, pulse `song_done`, wrap to 31 and go to IDLE; otherwise go to FETCH.
- `ff_switch0` and `r_switch1` both high: reverse order with halved durations.
- `song` is sampled at FETCH. A change mid-song takes effect on the next fetch, and note_idx is not cleared.
- `play` low in any state other than WAIT: the FSM finishes the current fetch and stops in WAIT; no `new_note` is lost.

## Timing
- Reset values: `note`=0, `duration`=0, `new_note`=0, `song_done`=0, `activate`=0, note_idx=0, state IDLE.
- Reset is asynchronous and dominates everything, including mid-note.
- ROM is synchronous read with 1-cycle latency.
- With `activate_done` held 1: `play` sampled in IDLE at edge N → `activate` high in cycle N+3 → `new_note` high in cycle N+4.
- Note to note: `note_done` sampled at edge M → next `new_note` at cycle M+5.
- `song_done` is asserted in the NEXT cycle only; `new_note` and `song_done` are never high together.
- After `song_done`, a held-high `play` restarts the same `song` from idle 1 cycle later.

## Structure
- Shared package: state enum, `NOTES_PER_SONG`, field widths (NOTE_W=6, DUR_W=6, IDX_W=5), ROM word layout.
- Sub-module `song_rom`: 128×12 synchronous ROM, init file. The rest is a single FSM plus index counter.

## Test plan
- Reset, `song`=0, `play`=1, `note_done`=1, `activate_done`=1 → `new_note` every 6 cycles with note/duration = ROM[0], ROM[1], …; outputs all 0 during reset.
- `note_done`=0 for 100 ns during a note → FSM stays in WAIT; outputs stable; no `new_note`.
- `play`=0 for 100 ns → no advance; resume continues from the same note_idx.
- Pulse `reset` mid-song → outputs 0 immediately; restart begins at ROM[{song,0}].
- Full song 1 forward → 32 `new_note` strobes, then one `song_done` after index 31, then restart at index 0.
- Song 0 with `ff_switch0`=1: ROM duration 8 → `duration`=4, ROM 1 → 1. With `r_switch1`=1 mid-song: indices decrement; `song_done` after index 0.

Source files
------------

// File: rtl/song_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : song_reader_pkg
//  Description : Shared types, field widths and ROM content for the song
//                sequencer. The ROM image is produced by rom_init() so that
//                the song table is a single elaborated constant.
//  Revision    : 1.0  initial release
// ============================================================================
package song_reader_pkg;

    localparam int NOTES_PER_SONG = 32;
    localparam int NUM_SONGS      = 4;
    localparam int ROM_DEPTH      = NUM_SONGS * NOTES_PER_SONG;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int IDX_W  = 5;
    localparam int SONG_W = 2;
    localparam int ADDR_W = SONG_W + IDX_W;
    localparam int WORD_W = NOTE_W + DUR_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

    // ROM word layout: {note[11:6], duration[5:0]}
    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } rom_word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ACT   = 3'd3,
        ST_NEW   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_NEXT  = 3'd6
    } state_t;

    // Fast-forward halves the duration but never turns a real note into a
    // zero-length one; a stored zero is left alone.
    function automatic logic [DUR_W-1:0] ff_scale(input logic [DUR_W-1:0] dur,
                                                  input logic             ff);
        if (!ff || dur == '0) return dur;
        if (dur == DUR_W'(1)) return dur;
        return dur >> 1;
    endfunction

    // Song table. The first words of song 0 carry the duration corner
    // values (8, 1, 0, 63); every 11th word offset by 5 is a rest.
    function automatic rom_word_t rom_init(input logic [ADDR_W-1:0] addr);
        rom_word_t   w;
        int unsigned a;
        a      = 32'(addr);
        w.note = (a % 11 == 5) ? '0 : NOTE_W'((a * 7 + 3) % 64);
        case (a)
            0:       w.dur = DUR_W'(8);
            1:       w.dur = DUR_W'(1);
            2:       w.dur = DUR_W'(0);
            3:       w.dur = DUR_W'(63);
            default: w.dur = DUR_W'((a * 5 + 2) % 64);
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/song_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : song_reader_if
//  Description : Control/handshake bundle between the MCU side, the song
//                sequencer and the note player.
//                master : drives play, song, note_done, ff_switch0,
//                         r_switch1, activate_done; observes the rest.
//                slave  : the sequencer; drives note, duration, new_note,
//                         song_done, activate.
//  Revision    : 1.0  initial release
// ============================================================================
interface song_reader_if;
    import song_reader_pkg::*;

    logic              play;
    logic [SONG_W-1:0] song;
    logic              note_done;
    logic              ff_switch0;
    logic              r_switch1;
    logic              activate_done;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              new_note;
    logic              song_done;
    logic              activate;

    modport master (
        output play, song, note_done, ff_switch0, r_switch1, activate_done,
        input  note, duration, new_note, song_done, activate
    );

    modport slave (
        input  play, song, note_done, ff_switch0, r_switch1, activate_done,
        output note, duration, new_note, song_done, activate
    );

endinterface
`default_nettype wire

// File: rtl/song_reader_rom.sv
`default_nettype none
// ============================================================================
//  Module      : song_rom
//  Description : 128 x 12 synchronous-read song ROM, one cycle latency.
//                Ports: clk, en (read enable), addr[6:0] = {song, note_idx},
//                data = {note, duration}.
//  Revision    : 1.0  initial release
// ============================================================================
module song_rom
    import song_reader_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output rom_word_t         data
);

    rom_word_t w_mem [ROM_DEPTH];

    generate
        for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
            assign w_mem[i] = rom_init(ADDR_W'(i));
        end
    endgenerate

    // Output register is the ROM read stage; no reset needed on data.
    always_ff @(posedge clk) begin
        if (en) begin
            data <= w_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// ============================================================================
//  Module      : song_reader
//  Description : Song sequencer. Walks a 4 x 32 note ROM and hands each
//                note/duration pair to the note player after an
//                activate/activate_done handshake. Supports fast-forward
//                (halved durations) and rewind (reverse order).
//                Ports: clk, reset (async, active-high),
//                       bus (song_reader_if.slave): play, song, note_done,
//                       ff_switch0, r_switch1, activate_done in;
//                       note, duration, new_note, song_done, activate out.
//  Revision    : 1.0  initial release
// ============================================================================
module song_reader
    import song_reader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    song_reader_if.slave  bus
);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_rev;      // direction captured when the note ends

    logic [ADDR_W-1:0] w_addr;
    logic              w_rom_en;
    rom_word_t         w_rom;

    // Song is taken live at FETCH, so a mid-song change applies on the next
    // fetch without touching the index.
    assign w_addr   = {bus.song, r_idx};
    assign w_rom_en = (r_state == ST_FETCH);

    song_rom u_rom (
        .clk  (clk),
        .en   (w_rom_en),
        .addr (w_addr),
        .data (w_rom)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_rev         <= 1'b0;
            bus.note      <= '0;
            bus.duration  <= '0;
            bus.new_note  <= 1'b0;
            bus.song_done <= 1'b0;
            bus.activate  <= 1'b0;
        end else begin
            // Both strobes last a single cycle.
            bus.new_note  <= 1'b0;
            bus.song_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.play) begin
                        r_state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end

                ST_LOAD: begin
                    bus.note     <= w_rom.note;
                    bus.duration <= ff_scale(w_rom.dur, bus.ff_switch0);
                    bus.activate <= 1'b1;
                    r_state      <= ST_ACT;
                end

                ST_ACT: begin
                    if (bus.activate_done) begin
                        bus.activate <= 1'b0;
                        bus.new_note <= 1'b1;
                        r_state      <= ST_NEW;
                    end
                end

                ST_NEW: begin
                    r_state <= ST_WAIT;
                end

                // Pausing only bites here: a fetch already under way always
                // completes and delivers its strobe before the FSM parks.
                ST_WAIT: begin
                    if (bus.note_done && bus.play) begin
                        r_rev         <= bus.r_switch1;
                        bus.song_done <= bus.r_switch1 ? (r_idx == '0)
                                                       : (r_idx == LAST_IDX);
                        r_state       <= ST_NEXT;
                    end
                end

                // The index width makes both wraps (31->0, 0->31) natural.
                ST_NEXT: begin
                    r_idx   <= r_rev ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
                    r_state <= bus.song_done ? ST_IDLE : ST_FETCH;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_song_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_song_reader
//  Description : Self-checking bench for song_reader. A table of duration
//                and direction vectors, hand-built timing sequences and a
//                randomised run compared with a note-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_song_reader;

    logic clk = 1'b0;
    logic reset;

    song_reader_if bus_if ();

    song_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int last_nn  = 0;

    // reference model state: which song/index the next note should come from
    int m_song;
    int m_idx;
    bit m_ff;
    bit m_rev;

    typedef struct {
        int idx;
        bit ff;
        int exp_dur;
        bit rev;
        int exp_sd;
    } vec_t;

    vec_t tbl [9];

    // ---------------- reference ROM and duration rule ----------------
    function automatic int ref_note(input int s, input int i);
        int a;
        a = s * 32 + i;
        if (a % 11 == 5) return 0;
        return (a * 7 + 3) % 64;
    endfunction

    function automatic int ref_dur(input int s, input int i);
        int a;
        a = s * 32 + i;
        if (a == 0) return 8;
        if (a == 1) return 1;
        if (a == 2) return 0;
        if (a == 3) return 63;
        return (a * 5 + 2) % 64;
    endfunction

    function automatic int ref_scaled(input int d, input bit ff);
        if (!ff || d == 0) return d;
        return (d / 2 < 1) ? 1 : d / 2;
    endfunction

    function automatic int model_end();
        return m_rev ? int'(m_idx == 0) : int'(m_idx == 31);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit play_during);
        reset                = 1'b1;
        bus_if.play          = play_during;
        bus_if.song          = 2'd0;
        bus_if.note_done     = play_during;
        bus_if.ff_switch0    = 1'b0;
        bus_if.r_switch1     = 1'b0;
        bus_if.activate_done = 1'b1;
        repeat (3) step();
        chk("rst_note",      int'(bus_if.note),      0);
        chk("rst_duration",  int'(bus_if.duration),  0);
        chk("rst_new_note",  int'(bus_if.new_note),  0);
        chk("rst_song_done", int'(bus_if.song_done), 0);
        chk("rst_activate",  int'(bus_if.activate),  0);
        reset            = 1'b0;
        bus_if.play      = 1'b0;
        bus_if.note_done = 1'b0;
        m_song = 0; m_idx = 0; m_ff = 0; m_rev = 0;
        step();
    endtask

    // Waits for the next new_note, compares it, then steps into WAIT.
    task automatic do_note(input string tag, input bit rnd, input int exp_note,
                           input int exp_dur, output int lat_new, output int lat_act);
        lat_new = -1;
        lat_act = -1;
        for (int k = 1; k <= 100; k++) begin
            if (rnd) begin
                bus_if.play          = 1'($urandom_range(0, 1));
                bus_if.activate_done = 1'($urandom_range(0, 1));
            end
            step();
            if (bus_if.activate && lat_act < 0) lat_act = k;
            if (bus_if.new_note) begin
                lat_new = k;
                break;
            end
        end
        if (lat_new < 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            last_nn = cyc;
            chk({tag, "_note"},     int'(bus_if.note),      exp_note);
            chk({tag, "_duration"}, int'(bus_if.duration),  exp_dur);
            chk({tag, "_nn_and_sd"}, int'(bus_if.song_done), 0);
            step();
            chk({tag, "_strobe_len"}, int'(bus_if.new_note), 0);
        end
    endtask

    task automatic note_model(input string tag, input bit rnd, output int lat_new);
        int la;
        do_note(tag, rnd, ref_note(m_song, m_idx),
                ref_scaled(ref_dur(m_song, m_idx), m_ff), lat_new, la);
    endtask

    // Ends the current note; returns at the NEXT-state cycle.
    task automatic advance(input string tag, input int exp_sd);
        bus_if.r_switch1 = m_rev;
        bus_if.note_done = 1'b1;
        bus_if.play      = 1'b1;
        step();
        bus_if.note_done = 1'b0;
        chk({tag, "_song_done"}, int'(bus_if.song_done), exp_sd);
        m_idx = m_rev ? (m_idx + 31) % 32 : (m_idx + 1) % 32;
    endtask

    // Holds inputs for n cycles while parked in WAIT; nothing may move.
    task automatic hold_check(input string tag, input bit p, input bit nd, input int n);
        logic [5:0] n0, d0;
        int bad;
        n0 = bus_if.note;
        d0 = bus_if.duration;
        bad = 0;
        bus_if.play      = p;
        bus_if.note_done = nd;
        for (int k = 0; k < n; k++) begin
            step();
            if (bus_if.new_note || bus_if.activate || bus_if.song_done ||
                bus_if.note != n0 || bus_if.duration != d0) bad = 1;
        end
        bus_if.note_done = 1'b0;
        chk(tag, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int ln, la, t0, seen;
        reset = 1'b1;

        tbl[0] = '{0,  1'b1, 4,  1'b0, 0};
        tbl[1] = '{1,  1'b1, 1,  1'b0, 0};
        tbl[2] = '{2,  1'b1, 0,  1'b0, 0};
        tbl[3] = '{3,  1'b1, 31, 1'b1, 0};
        tbl[4] = '{2,  1'b0, 0,  1'b1, 0};
        tbl[5] = '{1,  1'b0, 1,  1'b1, 0};
        tbl[6] = '{0,  1'b0, 8,  1'b1, 1};
        tbl[7] = '{31, 1'b0, 29, 1'b0, 1};
        tbl[8] = '{0,  1'b1, 4,  1'b0, 0};

        // ---- reset values with play already high, then start-up latency
        do_reset(1'b1);
        bus_if.play = 1'b1;
        do_note("first", 1'b0, ref_note(0, 0), ref_dur(0, 0), ln, la);
        chk("first_act_latency", la, 3);
        chk("first_nn_latency",  ln, 4);

        advance("n2n", 0);
        note_model("n2n", 1'b0, ln);
        chk("n2n_latency", ln + 1, 5);

        // ---- note_done held: one strobe every 6 cycles
        bus_if.note_done = 1'b1;
        for (int n = 0; n < 3; n++) begin
            t0 = last_nn;
            m_idx = (m_idx + 1) % 32;
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                step();
                if (bus_if.new_note) seen = 1;
            end
            chk("period_seen", seen, 1);
            chk("period_gap", cyc - t0, 6);
            chk("period_note", int'(bus_if.note), ref_note(m_song, m_idx));
            last_nn = cyc;
        end
        bus_if.note_done = 1'b0;
        step();

        // ---- activate held until acknowledged
        advance("hs", 0);
        bus_if.activate_done = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus_if.new_note) seen = 1;
        end
        chk("hs_no_new_note", seen, 0);
        chk("hs_activate_held", int'(bus_if.activate), 1);
        bus_if.activate_done = 1'b1;
        note_model("hs", 1'b0, ln);
        chk("hs_ack_latency", ln, 1);

        // ---- note_done low, then pause with note_done high: no advance
        hold_check("hold_nd_low", 1'b1, 1'b0, 10);
        hold_check("hold_paused", 1'b0, 1'b1, 10);
        advance("resume", 0);
        note_model("resume", 1'b0, ln);

        // ---- asynchronous reset in the middle of a handshake
        advance("mid", 0);
        bus_if.activate_done = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (bus_if.activate) seen = 1;
        end
        chk("mid_activate_seen", seen, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_activate", int'(bus_if.activate), 0);
        chk("mid_rst_note",     int'(bus_if.note),     0);
        chk("mid_rst_duration", int'(bus_if.duration), 0);
        step();
        reset = 1'b0;
        m_idx = 0;
        bus_if.activate_done = 1'b1;
        bus_if.play = 1'b1;
        note_model("restart", 1'b0, ln);

        // ---- table: fast-forward scaling and rewind across the song edge
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) begin
            bus_if.ff_switch0 = tbl[i].ff;
            bus_if.play       = 1'b1;
            do_note($sformatf("tbl%0d", i), 1'b0, ref_note(0, tbl[i].idx),
                    tbl[i].exp_dur, ln, la);
            m_rev = tbl[i].rev;
            advance($sformatf("tbl%0d", i), tbl[i].exp_sd);
        end

        // ---- full song 1 forward, then restart from index 0
        do_reset(1'b0);
        m_song = 1;
        bus_if.song = 2'd1;
        bus_if.play = 1'b1;
        seen = 0;
        for (int i = 0; i < 32; i++) begin
            note_model("song1", 1'b0, ln);
            if (ln > 0) seen++;
            advance("song1", int'(i == 31));
        end
        chk("song1_strobes", seen, 32);
        note_model("song1_restart", 1'b0, ln);
        chk("song1_restart_latency", ln, 5);
        advance("song1_after", 0);

        // ---- randomised run against the note-level model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                m_song = $urandom_range(0, 3);
                bus_if.song = 2'(m_song);
            end
            m_ff = 1'($urandom_range(0, 1));
            bus_if.ff_switch0 = m_ff;
            note_model("rnd", 1'b1, ln);
            if ($urandom_range(0, 1) == 1)
                hold_check("rnd_hold", 1'b0, 1'($urandom_range(0, 1)),
                           $urandom_range(1, 4));
            m_rev = 1'($urandom_range(0, 1));
            advance("rnd", model_end());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
